// File: rtl/rv32i_csr_pkg.sv
// Shared constants for the rv32i machine-mode CSR file: address map, access
// command encodings and mstatus field positions.
package rv32i_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'b000,
    CMD_WRITE = 3'b001,
    CMD_SET   = 3'b010,
    CMD_CLEAR = 3'b011,
    CMD_READ  = 3'b100
  } csr_cmd_e;

  localparam int          MSTATUS_MIE    = 3;
  localparam int          MSTATUS_MPIE   = 7;
  localparam int          MSTATUS_MPP_LO = 11;
  localparam logic [1:0]  MSTATUS_MPP    = 2'b11;

endpackage

// File: rtl/rv32i_csr_counter.sv
// 64-bit free-running counter with half-word (XLEN=32) or full (XLEN=64)
// software writes; any write suppresses that cycle's increment.
module rv32i_csr_counter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            wr_lo,
  input  logic            wr_hi,
  input  logic [XLEN-1:0] wdata,
  output logic [63:0]     count
);

  logic [63:0] count_d;

  always_comb begin
    count_d = count;
    if (wr_lo) begin
      if (XLEN == 64) count_d = 64'(wdata);
      else            count_d[31:0] = wdata[31:0];
    end
    if (wr_hi) count_d[63:32] = wdata[31:0];
    if (!(wr_lo || wr_hi) && inc) count_d = count + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count_d;
  end

endmodule

// File: rtl/rv32i_csr_file.sv
// Machine-mode CSR file: one-cycle swap-style CSR access, trap entry / mret
// bookkeeping and the mcycle/minstret counters.
module rv32i_csr_file
  import rv32i_csr_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int unsigned     HART_ID   = 0,
  parameter logic [XLEN-1:0] MTVEC_RST = '0,
  parameter bit              CNT_EN    = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_en,
  input  logic [11:0]     csr_addr,
  input  logic [2:0]      csr_cmd,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            instret,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] epc_out,
  output logic            mie_out
);

  // The *h halves only exist on RV32 with counters present.
  localparam bit HI_OK = (XLEN == 32) && CNT_EN;

  logic            mie_q, mpie_q;
  logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0]     cyc, ins;
  logic            access, cmd_bad, is_wr, addr_ok, illegal, we;
  logic [XLEN-1:0] old_val, new_val, mstatus_val;

  always_comb begin
    mstatus_val = '0;
    mstatus_val[MSTATUS_MIE]  = mie_q;
    mstatus_val[MSTATUS_MPIE] = mpie_q;
    mstatus_val[MSTATUS_MPP_LO+1:MSTATUS_MPP_LO] = MSTATUS_MPP;
  end

  always_comb begin
    old_val = '0;
    addr_ok = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:   old_val = mstatus_val;
      CSR_MTVEC:     old_val = mtvec_q;
      CSR_MSCRATCH:  old_val = mscratch_q;
      CSR_MEPC:      old_val = mepc_q;
      CSR_MCAUSE:    old_val = mcause_q;
      CSR_MTVAL:     old_val = mtval_q;
      CSR_MCYCLE:    begin old_val = cyc[XLEN-1:0];       addr_ok = CNT_EN; end
      CSR_MCYCLEH:   begin old_val = XLEN'(cyc[63:32]);   addr_ok = HI_OK;  end
      CSR_MINSTRET:  begin old_val = ins[XLEN-1:0];       addr_ok = CNT_EN; end
      CSR_MINSTRETH: begin old_val = XLEN'(ins[63:32]);   addr_ok = HI_OK;  end
      CSR_MHARTID:   old_val = XLEN'(HART_ID);
      default:       addr_ok = 1'b0;
    endcase
  end

  always_comb begin
    new_val = old_val;
    case (csr_cmd)
      CMD_WRITE: new_val = csr_wdata;
      CMD_SET:   new_val = old_val | csr_wdata;
      CMD_CLEAR: new_val = old_val & ~csr_wdata;
      default:   new_val = old_val;
    endcase
  end

  assign access  = csr_en && (csr_cmd != CMD_NOP);
  assign cmd_bad = csr_cmd > CMD_READ;
  assign is_wr   = (csr_cmd == CMD_WRITE) || (csr_cmd == CMD_SET) || (csr_cmd == CMD_CLEAR);
  assign illegal = access && (!addr_ok || cmd_bad || (is_wr && csr_addr == CSR_MHARTID));
  // SET/CLEAR with a zero mask never writes, so counters keep counting.
  assign we      = access && !illegal && is_wr && !trap_en && !mret &&
                   ((csr_cmd == CMD_WRITE) || (csr_wdata != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rdata   <= '0;
      csr_illegal <= 1'b0;
      mie_q       <= 1'b0;
      mpie_q      <= 1'b0;
      mtvec_q     <= MTVEC_RST;
      mscratch_q  <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtval_q     <= '0;
    end else begin
      csr_illegal <= illegal;
      if (access) csr_rdata <= illegal ? '0 : old_val;
      if (trap_en) begin
        mepc_q   <= trap_pc & ~XLEN'(3);
        mcause_q <= trap_cause;
        mtval_q  <= trap_tval;
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else if (mret) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mie_q  <= new_val[MSTATUS_MIE];
            mpie_q <= new_val[MSTATUS_MPIE];
          end
          CSR_MTVEC:    mtvec_q <= {new_val[XLEN-1:2], new_val[1] ? mtvec_q[1:0] : new_val[1:0]};
          CSR_MSCRATCH: mscratch_q <= new_val;
          CSR_MEPC:     mepc_q     <= new_val & ~XLEN'(3);
          CSR_MCAUSE:   mcause_q   <= new_val;
          CSR_MTVAL:    mtval_q    <= new_val;
          default: ;
        endcase
      end
    end
  end

  generate
    if (CNT_EN) begin : g_cnt
      rv32i_csr_counter #(.XLEN(XLEN)) u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .wr_lo (we && csr_addr == CSR_MCYCLE),
        .wr_hi (we && csr_addr == CSR_MCYCLEH),
        .wdata (new_val),
        .count (cyc)
      );
      rv32i_csr_counter #(.XLEN(XLEN)) u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (instret),
        .wr_lo (we && csr_addr == CSR_MINSTRET),
        .wr_hi (we && csr_addr == CSR_MINSTRETH),
        .wdata (new_val),
        .count (ins)
      );
    end else begin : g_no_cnt
      assign cyc = '0;
      assign ins = '0;
    end
  endgenerate

  // Vectored mode adds 4*cause for interrupts only.
  assign trap_vector = {mtvec_q[XLEN-1:2], 2'b00} +
                       ((mtvec_q[1:0] == 2'b01 && trap_cause[XLEN-1]) ? {trap_cause[XLEN-3:0], 2'b00} : '0);
  assign epc_out     = mepc_q;
  assign mie_out     = mie_q;

endmodule

// File: tb/tb_rv32i_csr_file.sv
// Self-checking bench for rv32i_csr_file: table of single accesses plus
// hand-written trap, priority, counter-wrap and async-reset sequences.
module tb_rv32i_csr_file;
  import rv32i_csr_pkg::*;

  localparam int          XLEN      = 32;
  localparam int unsigned HART_ID   = 3;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0200;

  logic            clk, rst_n, csr_en, csr_illegal, instret, trap_en, mret, mie_out;
  logic [11:0]     csr_addr;
  logic [2:0]      csr_cmd;
  logic [XLEN-1:0] csr_wdata, csr_rdata, trap_pc, trap_cause, trap_tval, trap_vector, epc_out;

  rv32i_csr_file #(.XLEN(XLEN), .HART_ID(HART_ID), .MTVEC_RST(MTVEC_RST), .CNT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .csr_en(csr_en), .csr_addr(csr_addr), .csr_cmd(csr_cmd),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .instret(instret),
    .trap_en(trap_en), .trap_pc(trap_pc), .trap_cause(trap_cause), .trap_tval(trap_tval),
    .mret(mret), .trap_vector(trap_vector), .epc_out(epc_out), .mie_out(mie_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cmd;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        ill;
  } vec_t;

  vec_t        vecs[$];
  logic [33:0] exp_q[$];  // {check_rdata, illegal, rdata}
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_rd  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] cmd, input logic [11:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rd, input logic ill);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.wdata = wdata; v.rd = rd; v.ill = ill;
    vecs.push_back(v);
  endtask

  // driver: one access per clock, called and returning at a falling edge
  task automatic access(input logic [2:0] cmd, input logic [11:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rd, input logic ill, input bit chk);
    logic [33:0] e;
    csr_en = 1'b1; csr_cmd = cmd; csr_addr = addr; csr_wdata = wdata;
    exp_q.push_back({chk, ill, rd});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check($sformatf("illegal addr=%h cmd=%0d", addr, cmd), {31'b0, csr_illegal}, {31'b0, e[32]});
    if (e[33]) check($sformatf("rdata addr=%h cmd=%0d", addr, cmd), csr_rdata, e[31:0]);
    last_rd = e[31:0];
    csr_en = 1'b0; csr_cmd = CMD_NOP;
    @(negedge clk);
  endtask

  task automatic idle();
    csr_en = 1'b0; csr_cmd = CMD_NOP;
    @(posedge clk); #1;
    check("idle illegal", {31'b0, csr_illegal}, 32'd0);
    check("idle rdata hold", csr_rdata, last_rd);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_n = 1'b0; csr_en = 1'b0; csr_cmd = CMD_NOP; csr_addr = '0; csr_wdata = '0;
    instret = 1'b0; trap_en = 1'b0; mret = 1'b0; trap_pc = '0; trap_cause = '0; trap_tval = '0;
    repeat (2) @(negedge clk);
    check("reset rdata", csr_rdata, 32'd0);
    check("reset illegal", {31'b0, csr_illegal}, 32'd0);
    check("reset epc", epc_out, 32'd0);
    check("reset mie", {31'b0, mie_out}, 32'd0);
    check("reset trap_vector", trap_vector, MTVEC_RST);
    rst_n = 1'b1;
    @(negedge clk);

    add(CMD_WRITE, CSR_MTVEC,    32'h0000_1001, MTVEC_RST,     1'b0);
    add(CMD_READ,  CSR_MTVEC,    32'h0,         32'h0000_1001, 1'b0);
    add(CMD_WRITE, CSR_MTVEC,    32'h0000_1003, 32'h0000_1001, 1'b0);
    add(CMD_READ,  CSR_MTVEC,    32'h0,         32'h0000_1001, 1'b0);
    add(CMD_READ,  CSR_MSTATUS,  32'h0,         32'h0000_1800, 1'b0);
    add(CMD_WRITE, CSR_MSTATUS,  32'h8,         32'h0000_1800, 1'b0);
    add(CMD_SET,   CSR_MSTATUS,  32'h80,        32'h0000_1808, 1'b0);
    add(CMD_READ,  CSR_MSTATUS,  32'h0,         32'h0000_1888, 1'b0);
    add(CMD_CLEAR, CSR_MSTATUS,  32'h8,         32'h0000_1888, 1'b0);
    add(CMD_READ,  CSR_MSTATUS,  32'h0,         32'h0000_1880, 1'b0);
    add(CMD_WRITE, CSR_MSTATUS,  32'hFFFF_FFFF, 32'h0000_1880, 1'b0);
    add(CMD_READ,  CSR_MSTATUS,  32'h0,         32'h0000_1888, 1'b0);
    add(CMD_WRITE, CSR_MSCRATCH, 32'hDEAD_BEEF, 32'h0,         1'b0);
    add(CMD_SET,   CSR_MSCRATCH, 32'h0,         32'hDEAD_BEEF, 1'b0);
    add(CMD_CLEAR, CSR_MSCRATCH, 32'h0000_FFFF, 32'hDEAD_BEEF, 1'b0);
    add(CMD_READ,  CSR_MSCRATCH, 32'h0,         32'hDEAD_0000, 1'b0);
    add(CMD_WRITE, CSR_MEPC,     32'h1234_5677, 32'h0,         1'b0);
    add(CMD_READ,  CSR_MEPC,     32'h0,         32'h1234_5674, 1'b0);
    add(CMD_WRITE, CSR_MCAUSE,   32'h8000_0003, 32'h0,         1'b0);
    add(CMD_READ,  CSR_MCAUSE,   32'h0,         32'h8000_0003, 1'b0);
    add(CMD_WRITE, CSR_MTVAL,    32'h0000_00A5, 32'h0,         1'b0);
    add(CMD_READ,  CSR_MTVAL,    32'h0,         32'h0000_00A5, 1'b0);
    add(CMD_READ,  12'h7C0,      32'h0,         32'h0,         1'b1);
    add(CMD_READ,  CSR_MSTATUS,  32'h0,         32'h0000_1888, 1'b0);
    add(CMD_WRITE, CSR_MHARTID,  32'h5,         32'h0,         1'b1);
    add(CMD_READ,  CSR_MHARTID,  32'h0,         HART_ID,       1'b0);
    add(CMD_SET,   CSR_MHARTID,  32'h0,         32'h0,         1'b1);
    add(3'b101,    CSR_MSCRATCH, 32'h1,         32'h0,         1'b1);
    add(3'b111,    CSR_MSTATUS,  32'h0,         32'h0,         1'b1);
    add(CMD_READ,  CSR_MSCRATCH, 32'h0,         32'hDEAD_0000, 1'b0);
    foreach (vecs[i]) access(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].ill, 1'b1);
    idle();

    // trap entry with vectored mtvec, then mret
    access(CMD_WRITE, CSR_MSTATUS, 32'h8, 32'h0000_1888, 1'b0, 1'b1);
    trap_en = 1'b1; trap_pc = 32'h0000_0106; trap_cause = 32'h0000_0007; trap_tval = 32'h55;
    #1 check("trap_vector exception", trap_vector, 32'h0000_1000);
    trap_cause = 32'h8000_0007;
    #1 check("trap_vector interrupt", trap_vector, 32'h0000_101C);
    idle();
    trap_en = 1'b0;
    check("trap epc", epc_out, 32'h0000_0104);
    check("trap mie", {31'b0, mie_out}, 32'd0);
    access(CMD_READ, CSR_MSTATUS, 32'h0, 32'h0000_1880, 1'b0, 1'b1);
    access(CMD_READ, CSR_MCAUSE,  32'h0, 32'h8000_0007, 1'b0, 1'b1);
    access(CMD_READ, CSR_MTVAL,   32'h0, 32'h0000_0055, 1'b0, 1'b1);
    mret = 1'b1;
    idle();
    mret = 1'b0;
    check("mret mie", {31'b0, mie_out}, 32'd1);
    access(CMD_READ, CSR_MSTATUS, 32'h0, 32'h0000_1888, 1'b0, 1'b1);

    // trap beats a same-cycle CSR write, old value still returned
    trap_en = 1'b1; trap_pc = 32'h0000_2002; trap_cause = 32'h2; trap_tval = 32'h0;
    access(CMD_WRITE, CSR_MEPC, 32'hFFFF_FFFF, 32'h0000_0104, 1'b0, 1'b1);
    trap_en = 1'b0;
    check("trap over write epc", epc_out, 32'h0000_2000);
    access(CMD_READ, CSR_MEPC,    32'h0, 32'h0000_2000, 1'b0, 1'b1);
    access(CMD_READ, CSR_MSTATUS, 32'h0, 32'h0000_1880, 1'b0, 1'b1);
    // mret beats a CSR write
    mret = 1'b1;
    access(CMD_WRITE, CSR_MSCRATCH, 32'h1, 32'hDEAD_0000, 1'b0, 1'b1);
    mret = 1'b0;
    check("mret over write mie", {31'b0, mie_out}, 32'd1);
    access(CMD_READ, CSR_MSCRATCH, 32'h0, 32'hDEAD_0000, 1'b0, 1'b1);
    // trap beats mret
    trap_en = 1'b1; mret = 1'b1; trap_pc = 32'h0000_0300;
    idle();
    trap_en = 1'b0; mret = 1'b0;
    check("trap over mret mie", {31'b0, mie_out}, 32'd0);
    check("trap over mret epc", epc_out, 32'h0000_0300);

    // mcycle 64-bit wrap via two half writes
    access(CMD_WRITE, CSR_MCYCLE,  32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
    access(CMD_WRITE, CSR_MCYCLEH, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
    idle();
    access(CMD_READ, CSR_MCYCLE,  32'h0, 32'h0, 1'b0, 1'b1);
    access(CMD_READ, CSR_MCYCLEH, 32'h0, 32'h0, 1'b0, 1'b1);
    access(CMD_READ, CSR_MCYCLE,  32'h0, 32'h2, 1'b0, 1'b1);

    // minstret: write suppresses increment, reads return pre-increment value
    instret = 1'b1;
    access(CMD_WRITE, CSR_MINSTRET, 32'h10, 32'h0,  1'b0, 1'b1);
    access(CMD_READ,  CSR_MINSTRET, 32'h0,  32'h10, 1'b0, 1'b1);
    instret = 1'b0;
    access(CMD_READ,  CSR_MINSTRETH, 32'h0, 32'h0,  1'b0, 1'b1);
    access(CMD_READ,  CSR_MINSTRET,  32'h0, 32'h11, 1'b0, 1'b1);

    // asynchronous reset in the middle of an access
    csr_en = 1'b1; csr_cmd = CMD_WRITE; csr_addr = CSR_MSCRATCH; csr_wdata = 32'h77;
    #2 rst_n = 1'b0;
    #1;
    check("async rst rdata", csr_rdata, 32'd0);
    check("async rst epc", epc_out, 32'd0);
    check("async rst trap_vector", trap_vector, MTVEC_RST);
    @(posedge clk); #1;
    csr_en = 1'b0; csr_cmd = CMD_NOP;
    check("in rst illegal", {31'b0, csr_illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(CMD_READ, CSR_MSCRATCH, 32'h0, 32'h0,         1'b0, 1'b1);
    access(CMD_READ, CSR_MTVEC,    32'h0, MTVEC_RST,     1'b0, 1'b1);
    access(CMD_READ, CSR_MSTATUS,  32'h0, 32'h0000_1800, 1'b0, 1'b1);
    access(CMD_READ, CSR_MINSTRET, 32'h0, 32'h0,         1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
